// File: rtl/snake_body_store.sv
// Snake body segment store: circular buffer of head..tail coordinates with a
// registered read port for the renderer and a sequential self-collision scanner.
module snake_body_store #(
  parameter int X_BITS   = 6,
  parameter int Y_BITS   = 6,
  parameter int S_LEN_W  = 8,
  parameter int S_ADDR_W = 8,
  parameter int INIT_LEN = 3,
  parameter int START_X  = 30,
  parameter int START_Y  = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init,
  input  logic                step,
  input  logic                grow,
  input  logic [X_BITS-1:0]   nh_x,
  input  logic [Y_BITS-1:0]   nh_y,
  input  logic                chk_req,
  input  logic [X_BITS-1:0]   chk_x,
  input  logic [Y_BITS-1:0]   chk_y,
  input  logic                chk_no_tail,
  output logic                chk_done,
  output logic                chk_hit,
  output logic                busy,
  output logic [X_BITS-1:0]   hx,
  output logic [Y_BITS-1:0]   hy,
  output logic [S_LEN_W-1:0]  len,
  input  logic [S_ADDR_W-1:0] q_addr,
  output logic [X_BITS-1:0]   q_x,
  output logic [Y_BITS-1:0]   q_y,
  output logic                q_vld
);

  localparam int DEPTH   = 2**S_ADDR_W;
  localparam int MAX_LEN = DEPTH - 1;

  typedef enum logic [1:0] {IDLE, INIT, SCAN} state_e;
  typedef struct packed {
    logic [X_BITS-1:0] x;
    logic [Y_BITS-1:0] y;
  } seg_t;

  seg_t mem [DEPTH];

  state_e              state_q, state_d;
  logic [S_ADDR_W-1:0] hp_q, hp_d;
  logic [S_ADDR_W-1:0] cnt_q, cnt_d;
  logic [S_LEN_W-1:0]  len_q, len_d;
  logic [S_LEN_W-1:0]  scan_q, scan_d;
  logic [S_LEN_W-1:0]  last_q, last_d;
  seg_t                head_q, head_d;
  seg_t                cand_q, cand_d;
  seg_t                qseg_q, qseg_d;
  logic                q_vld_q, q_vld_d;
  logic                hit_q, hit_d;
  logic                done_q, done_d;

  logic                we;
  logic [S_ADDR_W-1:0] waddr;
  seg_t                wdata;
  seg_t                scan_seg;
  seg_t                rd_seg;

  // Logical index i lives at physical slot hp - i; subtraction wraps mod DEPTH.
  assign scan_seg = mem[hp_q - S_ADDR_W'(scan_q)];
  assign rd_seg   = mem[hp_q - q_addr];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    hp_d    = hp_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    scan_d  = scan_q;
    last_d  = last_q;
    head_d  = head_q;
    cand_d  = cand_q;
    hit_d   = hit_q;
    done_d  = 1'b0;
    we      = 1'b0;
    waddr   = '0;
    wdata   = '0;

    unique case (state_q)
      IDLE: begin
        if (init) begin
          state_d = INIT;
          cnt_d   = '0;
          len_d   = '0;
        end else if (chk_req) begin
          hit_d  = 1'b0;
          cand_d = '{x: chk_x, y: chk_y};
          scan_d = '0;
          if (len_q == '0 || (len_q == S_LEN_W'(1) && chk_no_tail)) begin
            done_d = 1'b1;
          end else begin
            last_d  = chk_no_tail ? len_q - S_LEN_W'(2) : len_q - S_LEN_W'(1);
            state_d = SCAN;
          end
        end else if (step) begin
          hp_d   = hp_q + S_ADDR_W'(1);
          we     = 1'b1;
          waddr  = hp_q + S_ADDR_W'(1);
          wdata  = '{x: nh_x, y: nh_y};
          head_d = '{x: nh_x, y: nh_y};
          if (grow && len_q < S_LEN_W'(MAX_LEN)) len_d = len_q + S_LEN_W'(1);
        end
      end

      INIT: begin
        if (init) begin
          cnt_d = '0;
        end else begin
          // Segment k sits at physical INIT_LEN-1-k so the head ends at hp=INIT_LEN-1.
          we    = 1'b1;
          waddr = S_ADDR_W'(INIT_LEN - 1) - cnt_q;
          wdata = '{x: X_BITS'(START_X) - X_BITS'(cnt_q), y: Y_BITS'(START_Y)};
          if (cnt_q == S_ADDR_W'(INIT_LEN - 1)) begin
            hp_d    = S_ADDR_W'(INIT_LEN - 1);
            len_d   = S_LEN_W'(INIT_LEN);
            head_d  = '{x: X_BITS'(START_X), y: Y_BITS'(START_Y)};
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + S_ADDR_W'(1);
          end
        end
      end

      SCAN: begin
        if (init) begin
          state_d = INIT;
          cnt_d   = '0;
          len_d   = '0;
        end else if (scan_seg == cand_q) begin
          hit_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (scan_q == last_q) begin
          hit_d   = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          scan_d = scan_q + S_LEN_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Reads sample pre-update hp/len/mem because all state commits on the same edge.
  always_comb begin
    q_vld_d = (32'(q_addr) < 32'(len_q)) && (state_q != INIT);
    qseg_d  = q_vld_d ? rd_seg : qseg_q;
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hp_q    <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      scan_q  <= '0;
      last_q  <= '0;
      head_q  <= '0;
      cand_q  <= '0;
      qseg_q  <= '0;
      q_vld_q <= 1'b0;
      hit_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      scan_q  <= scan_d;
      last_q  <= last_d;
      head_q  <= head_d;
      cand_q  <= cand_d;
      qseg_q  <= qseg_d;
      q_vld_q <= q_vld_d;
      hit_q   <= hit_d;
      done_q  <= done_d;
    end
  end

  // NOTE: the segment memory has no reset; slots beyond len are never observable.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign busy     = (state_q != IDLE);
  assign chk_done = done_q;
  assign chk_hit  = hit_q;
  assign hx       = head_q.x;
  assign hy       = head_q.y;
  assign len      = len_q;
  assign q_x      = qseg_q.x;
  assign q_y      = qseg_q.y;
  assign q_vld    = q_vld_q;

endmodule

// File: tb/tb_snake_body_store.sv
// Randomized self-checking bench for snake_body_store against a queue-based body model.
module tb_snake_body_store;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       init, step, grow, chk_req, chk_no_tail;
  logic [5:0] nh_x, chk_x, q_x, hx;
  logic [5:0] nh_y, chk_y, q_y, hy;
  logic       chk_done, chk_hit, busy, q_vld;
  logic [7:0] len, q_addr;

  int checks = 0;
  int errors = 0;

  // Model: body[0] is the head, body[size-1] the tail; each entry {x,y}.
  logic [11:0] body[$];
  logic [5:0]  m_hx, m_hy;

  snake_body_store dut (
    .clk(clk), .rst_n(rst_n), .init(init), .step(step), .grow(grow),
    .nh_x(nh_x), .nh_y(nh_y), .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y),
    .chk_no_tail(chk_no_tail), .chk_done(chk_done), .chk_hit(chk_hit), .busy(busy),
    .hx(hx), .hy(hy), .len(len), .q_addr(q_addr), .q_x(q_x), .q_y(q_y), .q_vld(q_vld)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    body.delete();
    m_hx = '0;
    m_hy = '0;
  endtask

  task automatic model_init();
    logic [5:0] x;
    body.delete();
    for (int k = 0; k < 3; k++) begin
      x = 6'((30 - k) & 63);
      body.push_back({x, 6'd20});
    end
    m_hx = 6'd30;
    m_hy = 6'd20;
  endtask

  task automatic model_step(input logic [5:0] x, input logic [5:0] y, input logic g);
    int old_len;
    old_len = body.size();
    body.push_front({x, y});
    if (!g || old_len >= 255) void'(body.pop_back());
    m_hx = x;
    m_hy = y;
  endtask

  // Expected scan result: hit at first matching index i costs i+2 cycles, a miss last+2.
  task automatic model_scan(input logic [5:0] x, input logic [5:0] y, input logic nt,
                            output int lat, output logic hit);
    int last;
    last = nt ? body.size() - 2 : body.size() - 1;
    hit  = 1'b0;
    lat  = last + 2;
    for (int i = 0; i <= last; i++) begin
      if (body[i] == {x, y}) begin
        hit = 1'b1;
        lat = i + 2;
        break;
      end
    end
  endtask

  task automatic do_init();
    init = 1'b1;
    cyc();
    init = 1'b0;
  endtask

  task automatic do_step(input logic [5:0] x, input logic [5:0] y, input logic g);
    step = 1'b1; nh_x = x; nh_y = y; grow = g;
    cyc();
    step = 1'b0; grow = 1'b0;
    model_step(x, y, g);
  endtask

  task automatic rd(input logic [7:0] a, output logic v, output logic [5:0] x,
                    output logic [5:0] y);
    q_addr = a;
    cyc();
    v = q_vld; x = q_x; y = q_y;
  endtask

  task automatic run_chk(input logic [5:0] x, input logic [5:0] y, input logic nt,
                         output int lat, output logic hit);
    chk_x = x; chk_y = y; chk_no_tail = nt; chk_req = 1'b1;
    cyc();
    chk_req = 1'b0;
    lat = 1;
    while (!chk_done && lat < 600) begin
      cyc();
      lat++;
    end
    if (!chk_done) lat = -1;
    hit = chk_hit;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 20) begin
      cyc();
      n++;
    end
  endtask

  task automatic check_body(input string tag);
    logic v; logic [5:0] x, y; logic ev;
    for (int a = 0; a <= body.size() && a < 256; a++) begin
      rd(8'(a), v, x, y);
      ev = (a < body.size());
      checks++;
      if (v !== ev || (ev && {x, y} !== body[a])) begin
        errors++;
        $display("FAIL %s addr=%0d got vld=%b (%0d,%0d) want vld=%b (%0d,%0d)", tag, a,
                 v, x, y, ev, ev ? body[a][11:6] : 0, ev ? body[a][5:0] : 0);
      end
    end
  endtask

  task automatic test_reset();
    logic v; logic [5:0] x, y;
    checks++;
    if ({len, hx, hy, q_x, q_y, q_vld, chk_done, chk_hit, busy} !== '0) begin
      errors++;
      $display("FAIL reset_state got len=%0d hx=%0d hy=%0d qx=%0d qy=%0d vld=%b done=%b hit=%b busy=%b want all 0",
               len, hx, hy, q_x, q_y, q_vld, chk_done, chk_hit, busy);
    end
    rd(8'd0, v, x, y);
    checks++;
    if (v !== 1'b0 || x !== 6'd0 || y !== 6'd0) begin
      errors++;
      $display("FAIL reset_read got vld=%b (%0d,%0d) want vld=0 (0,0)", v, x, y);
    end
  endtask

  task automatic test_init();
    int n;
    do_init();
    model_init();
    wait_idle(n);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL init_busy got %0d cycles want 3", n);
    end
    checks++;
    if (len !== 8'd3 || hx !== m_hx || hy !== m_hy) begin
      errors++;
      $display("FAIL init_head got len=%0d (%0d,%0d) want len=3 (30,20)", len, hx, hy);
    end
    check_body("init_read");
  endtask

  task automatic test_step();
    logic v; logic [5:0] x, y;
    do_step(6'd31, 6'd20, 1'b0);
    checks++;
    if (len !== 8'(body.size()) || hx !== m_hx || hy !== m_hy) begin
      errors++;
      $display("FAIL step_head got len=%0d (%0d,%0d) want len=%0d (%0d,%0d)", len, hx, hy,
               body.size(), m_hx, m_hy);
    end
    check_body("step_read");
    rd(8'd2, v, x, y);
    rd(8'd3, v, x, y);
    checks++;
    if (v !== 1'b0 || x !== 6'd29 || y !== 6'd20) begin
      errors++;
      $display("FAIL read_hold got vld=%b (%0d,%0d) want vld=0 (29,20)", v, x, y);
    end
  endtask

  task automatic test_scan();
    int lat, elat; logic hit, ehit;
    run_chk(6'd29, 6'd20, 1'b1, lat, hit);
    checks++;
    if (lat !== 3 || hit !== 1'b0) begin
      errors++;
      $display("FAIL scan_no_tail got lat=%0d hit=%b want lat=3 hit=0", lat, hit);
    end
    cyc();
    checks++;
    if (chk_done !== 1'b0 || chk_hit !== 1'b0) begin
      errors++;
      $display("FAIL scan_pulse got done=%b hit=%b want done=0 hit=0", chk_done, chk_hit);
    end
    run_chk(6'd29, 6'd20, 1'b0, lat, hit);
    model_scan(6'd29, 6'd20, 1'b0, elat, ehit);
    checks++;
    if (lat !== elat || hit !== 1'b1) begin
      errors++;
      $display("FAIL scan_tail got lat=%0d hit=%b want lat=%0d hit=1", lat, hit, elat);
    end
    cyc();
    checks++;
    if (chk_done !== 1'b0 || chk_hit !== 1'b1) begin
      errors++;
      $display("FAIL scan_hold got done=%b hit=%b want done=0 hit=1", chk_done, chk_hit);
    end
    run_chk(6'd31, 6'd20, 1'b0, lat, hit);
    checks++;
    if (lat !== 2 || hit !== 1'b1) begin
      errors++;
      $display("FAIL scan_head got lat=%0d hit=%b want lat=2 hit=1", lat, hit);
    end
  endtask

  task automatic test_step_during_scan();
    int lat;
    chk_x = 6'd0; chk_y = 6'd0; chk_no_tail = 1'b0; chk_req = 1'b1;
    cyc();
    chk_req = 1'b0;
    step = 1'b1; nh_x = 6'd5; nh_y = 6'd5; grow = 1'b1;
    lat = 1;
    while (!chk_done && lat < 20) begin
      cyc();
      lat++;
    end
    step = 1'b0; grow = 1'b0;
    checks++;
    if (lat !== 4 || chk_hit !== 1'b0 || len !== 8'(body.size()) || hx !== m_hx || hy !== m_hy) begin
      errors++;
      $display("FAIL step_in_scan got lat=%0d hit=%b len=%0d (%0d,%0d) want lat=4 hit=0 len=%0d (%0d,%0d)",
               lat, chk_hit, len, hx, hy, body.size(), m_hx, m_hy);
    end
  endtask

  task automatic test_grow_saturate();
    do_step(6'd32, 6'd20, 1'b1);
    checks++;
    if (len !== 8'd4 || body[3] !== {6'd29, 6'd20}) begin
      errors++;
      $display("FAIL grow got len=%0d want 4", len);
    end
    check_body("grow_read");
    while (body.size() < 255) do_step(6'($urandom), 6'($urandom), 1'b1);
    checks++;
    if (len !== 8'd255) begin
      errors++;
      $display("FAIL grow_full got len=%0d want 255", len);
    end
    for (int i = 0; i < 3; i++) do_step(6'($urandom), 6'($urandom), 1'b1);
    checks++;
    if (len !== 8'd255 || hx !== m_hx || hy !== m_hy) begin
      errors++;
      $display("FAIL grow_saturate got len=%0d (%0d,%0d) want 255 (%0d,%0d)", len, hx, hy,
               m_hx, m_hy);
    end
    check_body("wrap_read");
  endtask

  task automatic test_init_abort_and_reset();
    int n; bit seen_done;
    chk_x = 6'd63; chk_y = 6'd63; chk_no_tail = 1'b0; chk_req = 1'b1;
    body[body.size() - 1] = body[body.size() - 1];
    cyc();
    chk_req = 1'b0;
    seen_done = chk_done;
    cyc();
    seen_done |= chk_done;
    init = 1'b1;
    cyc();
    init = 1'b0;
    seen_done |= chk_done;
    model_init();
    n = 0;
    while (busy && n < 20) begin
      cyc();
      n++;
      seen_done |= chk_done;
    end
    checks++;
    if (seen_done || n !== 3 || len !== 8'd3) begin
      errors++;
      $display("FAIL scan_abort got done_seen=%b busy=%0d len=%0d want done_seen=0 busy=3 len=3",
               seen_done, n, len);
    end
    check_body("abort_read");
    do_init();
    cyc();
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (len !== 8'd0 || q_vld !== 1'b0 || busy !== 1'b0 || hx !== 6'd0) begin
      errors++;
      $display("FAIL reset_mid_init got len=%0d vld=%b busy=%b hx=%0d want 0 0 0 0",
               len, q_vld, busy, hx);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    checks++;
    if (busy !== 1'b0 || len !== 8'd0) begin
      errors++;
      $display("FAIL after_reset got busy=%b len=%0d want busy=0 len=0", busy, len);
    end
  endtask

  task automatic test_random();
    int n, lat, elat; logic hit, ehit, v; logic [5:0] x, y; logic [7:0] a; logic [11:0] c;
    do_init();
    model_init();
    wait_idle(n);
    for (int it = 0; it < 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: do_step(6'($urandom), 6'($urandom), 1'($urandom));
        4, 5, 6: begin
          c = ($urandom_range(0, 1) == 0) ? body[$urandom_range(0, body.size() - 1)]
                                          : 12'($urandom);
          model_scan(c[11:6], c[5:0], 1'($urandom), elat, ehit);
          run_chk(c[11:6], c[5:0], chk_no_tail, lat, hit);
          model_scan(c[11:6], c[5:0], chk_no_tail, elat, ehit);
          checks++;
          if (lat !== elat || hit !== ehit) begin
            errors++;
            $display("FAIL rand_scan it=%0d got lat=%0d hit=%b want lat=%0d hit=%b", it, lat,
                     hit, elat, ehit);
          end
        end
        default: begin
          a = 8'($urandom_range(0, body.size() + 2));
          rd(a, v, x, y);
          checks++;
          if (v !== (a < body.size()) || (v && {x, y} !== body[a])) begin
            errors++;
            $display("FAIL rand_read it=%0d addr=%0d got vld=%b (%0d,%0d) want vld=%b",
                     it, a, v, x, y, a < body.size());
          end
        end
      endcase
    end
    checks++;
    if (len !== 8'(body.size()) || hx !== m_hx || hy !== m_hy) begin
      errors++;
      $display("FAIL rand_final got len=%0d (%0d,%0d) want len=%0d (%0d,%0d)", len, hx, hy,
               body.size(), m_hx, m_hy);
    end
    check_body("rand_body");
  endtask

  initial begin
    rst_n = 1'b0;
    init = 1'b0; step = 1'b0; grow = 1'b0; chk_req = 1'b0; chk_no_tail = 1'b0;
    nh_x = '0; nh_y = '0; chk_x = '0; chk_y = '0; q_addr = '0;
    model_reset();
    #22;
    rst_n = 1'b1;
    cyc();
    test_reset();
    test_init();
    test_step();
    test_scan();
    test_step_during_scan();
    test_grow_saturate();
    test_init_abort_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
